// File: rtl/load_store_unit_if.sv
// Request/response handshake and word-memory bus between the core, the LSU and data memory.
// master = core and memory side, slave = the load_store_unit.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_rd_en;
  logic        mem_wr_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_rd_en, mem_wr_en, mem_addr, mem_wdata
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_rd_en, mem_wr_en, mem_addr, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I byte/half/word load-store unit in front of a word-only data memory; sub-word stores use read-modify-write.
// Optional LSU_BOUNDS_CHECK_EN: addresses at or beyond 4*MEM_WORDS bytes are rejected as errors.
module load_store_unit #(
  parameter int MEM_WORDS = 256
) (
  input logic             clk,
  input logic             reset,
  load_store_unit_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  lat_f3;
  logic [31:0] lat_addr;
  logic [31:0] wr_word;
  logic [31:0] rdata_r;
  logic        err_r;
  logic        req_err;

  function automatic logic access_error(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    logic e;
    case (f3)
      3'b000:  e = 1'b0;
      3'b001:  e = addr[0];
      3'b010:  e = (addr[1:0] != 2'b00);
      3'b100:  e = we;
      3'b101:  e = we | addr[0];
      default: e = 1'b1;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [2:0] f3,
                                              input logic [1:0] off);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  return 32'(b);
      3'b001:  return 32'(h);
      3'b100:  return {24'h0, b};
      3'b101:  return {16'h0, h};
      default: return word;
    endcase
  endfunction

  // Only SB (funct3 000) and SH (001) ever reach the merge.
  function automatic logic [31:0] merge_lane(input logic [31:0] word, input logic [31:0] wdata,
                                             input logic [2:0] f3, input logic [1:0] off);
    logic [31:0] w;
    w = word;
    if (f3[1:0] == 2'b00) w[{off, 3'b000} +: 8] = wdata[7:0];
    else                  w[{off[1], 4'b0000} +: 16] = wdata[15:0];
    return w;
  endfunction

`ifdef LSU_BOUNDS_CHECK_EN
  localparam logic [31:0] BYTE_LIMIT = 32'(4 * MEM_WORDS);
  assign req_err = access_error(bus.req_we, bus.req_funct3, bus.req_addr) ||
                   (bus.req_addr >= BYTE_LIMIT);
`else
  assign req_err = access_error(bus.req_we, bus.req_funct3, bus.req_addr);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Datapath registers carry no reset; every output they feed is gated by state.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: if (bus.req_valid) begin
        lat_f3   <= bus.req_funct3;
        lat_addr <= bus.req_addr;
        wr_word  <= bus.req_wdata;
        rdata_r  <= '0;
        err_r    <= req_err;
      end
      LOAD:    rdata_r <= load_extend(bus.mem_rdata, lat_f3, lat_addr[1:0]);
      RMW_RD:  wr_word <= merge_lane(bus.mem_rdata, wr_word, lat_f3, lat_addr[1:0]);
      default: ;
    endcase
  end

  always_comb begin
    state_nxt      = state;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_rdata = '0;
    bus.resp_err   = 1'b0;
    bus.mem_rd_en  = 1'b0;
    bus.mem_wr_en  = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          if (req_err)                        state_nxt = RESP;
          else if (!bus.req_we)               state_nxt = LOAD;
          else if (bus.req_funct3 == 3'b010)  state_nxt = WRITE;
          else                                state_nxt = RMW_RD;
        end
      end
      LOAD, RMW_RD: begin
        bus.mem_rd_en = 1'b1;
        bus.mem_addr  = {lat_addr[31:2], 2'b00};
        state_nxt     = (state == LOAD) ? RESP : WRITE;
      end
      WRITE: begin
        bus.mem_wr_en = 1'b1;
        bus.mem_addr  = {lat_addr[31:2], 2'b00};
        bus.mem_wdata = wr_word;
        state_nxt     = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_rdata = rdata_r;
        bus.resp_err   = err_r;
        if (bus.resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and randomized bench for load_store_unit against a byte-array reference memory model.
module tb_load_store_unit;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  load_store_unit_if bus();
  load_store_unit #(.MEM_WORDS(256)) dut (.clk(clk), .reset(reset), .bus(bus));

  // Word memory device seen by the DUT; preloaded through the fill port while in reset.
  logic [31:0] mem [0:255];
  logic        fill_en;
  logic [7:0]  fill_idx;
  logic [31:0] fill_data;
  assign bus.mem_rdata = mem[bus.mem_addr[9:2]];
  always @(posedge clk) begin
    if (fill_en)            mem[fill_idx] <= fill_data;
    else if (bus.mem_wr_en) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
  end

  int wr_cnt = 0, rd_cnt = 0, both_cnt = 0;
  logic [31:0] last_wr_addr = '0;
  always @(posedge clk) begin
    if (bus.mem_wr_en) begin
      wr_cnt       <= wr_cnt + 1;
      last_wr_addr <= bus.mem_addr;
    end
    if (bus.mem_rd_en) rd_cnt <= rd_cnt + 1;
    if (bus.mem_wr_en && bus.mem_rd_en) both_cnt <= both_cnt + 1;
  end

  byte unsigned rmem [0:1023];
  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: little-endian byte memory, access size from funct3, result built arithmetically.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic err, output int lat, output int nwr,
                       output int nrd);
    int size;
    logic [31:0] v;
    size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    err  = (f3 == 3'b011) || (f3 >= 3'b110) || (we && f3[2]) || ((a % size) != 0);
`ifdef LSU_BOUNDS_CHECK_EN
    if (a >= 32'd1024) err = 1'b1;
`endif
    rd = '0; nwr = 0; nrd = 0; lat = 1;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < size; i++) rmem[a + i] = wd[8*i +: 8];
        nwr = 1;
        nrd = (size == 4) ? 0 : 1;
        lat = (size == 4) ? 2 : 3;
      end else begin
        v = '0;
        for (int i = 0; i < size; i++) v = v + (32'(rmem[a + i]) << (8 * i));
        if (size < 4 && !f3[2] && v[8*size-1]) v = v - (32'd1 << (8 * size));
        rd  = v;
        nrd = 1;
        lat = 2;
      end
    end
  endtask

  task automatic do_req(input string tag, input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int hold, output logic [31:0] got, output logic gerr);
    logic [31:0] erd;
    logic eerr;
    int elat, enwr, enrd, wr0, rd0, both0, lat;
    bit seen;
    model(we, f3, a, wd, erd, eerr, elat, enwr, enrd);
    @(negedge clk);
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3; bus.req_addr = a; bus.req_wdata = wd;
    wr0 = wr_cnt; rd0 = rd_cnt; both0 = both_cnt;
    @(posedge clk); #1;
    // Keep presenting junk requests while busy: they must be ignored.
    bus.req_we = 1'($urandom); bus.req_funct3 = 3'($urandom);
    bus.req_addr = $urandom; bus.req_wdata = $urandom;
    lat = 0; seen = 0; got = '0; gerr = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      @(negedge clk);
      lat++;
      seen = bus.resp_valid;
    end
    got = bus.resp_rdata; gerr = bus.resp_err;
    chk({tag, "_latency"}, 32'(lat), 32'(elat));
    chk({tag, "_rdata"}, got, erd);
    chk({tag, "_err"}, 32'(gerr), 32'(eerr));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, 32'(bus.resp_valid), 32'd1);
      chk({tag, "_hold_rdata"}, bus.resp_rdata, erd);
      chk({tag, "_hold_ready"}, 32'(bus.req_ready), 32'd0);
      chk({tag, "_hold_addr"}, bus.mem_addr, 32'd0);
    end
    bus.req_valid = 1'b0;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    chk({tag, "_after_valid"}, 32'(bus.resp_valid), 32'd0);
    chk({tag, "_after_ready"}, 32'(bus.req_ready), 32'd1);
    chk({tag, "_wr_count"}, 32'(wr_cnt - wr0), 32'(enwr));
    chk({tag, "_rd_count"}, 32'(rd_cnt - rd0), 32'(enrd));
    chk({tag, "_rd_wr_overlap"}, 32'(both_cnt - both0), 32'd0);
    if (enwr != 0) chk({tag, "_wr_addr"}, last_wr_addr, {a[31:2], 2'b00});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got, w;
    logic gerr;
    int wr0, nbad;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = '0; bus.req_addr = '0;
    bus.req_wdata = '0; bus.resp_ready = 1'b0;
    reset = 1'b1; fill_en = 1'b1; fill_idx = '0; fill_data = '0;

    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      w = $urandom;
      fill_idx = 8'(i); fill_data = w;
      for (int k = 0; k < 4; k++) rmem[4*i + k] = w[8*k +: 8];
    end
    @(negedge clk);
    fill_en = 1'b0;

    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
    chk("rst_mem_en", {30'd0, bus.mem_rd_en, bus.mem_wr_en}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    reset = 1'b0;

    do_req("t1_sw", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, got, gerr);
    do_req("t1_lw", 1'b0, 3'b010, 32'h10, 32'h0, 0, got, gerr);
    chk("t1_lw_value", got, 32'hDEADBEEF);

    do_req("t2_sb", 1'b1, 3'b000, 32'h11, 32'h000000AA, 0, got, gerr);
    do_req("t2_lw", 1'b0, 3'b010, 32'h10, 32'h0, 0, got, gerr);
    chk("t2_word", got, 32'hDEADAAEF);
    do_req("t2_lb", 1'b0, 3'b000, 32'h11, 32'h0, 0, got, gerr);
    chk("t2_lb_value", got, 32'hFFFFFFAA);
    do_req("t2_lbu", 1'b0, 3'b100, 32'h11, 32'h0, 0, got, gerr);
    chk("t2_lbu_value", got, 32'h000000AA);

    do_req("t3_sh", 1'b1, 3'b001, 32'h12, 32'h00001234, 0, got, gerr);
    do_req("t3_lw", 1'b0, 3'b010, 32'h10, 32'h0, 0, got, gerr);
    chk("t3_word", got, 32'h1234AAEF);
    do_req("t3_lh12", 1'b0, 3'b001, 32'h12, 32'h0, 0, got, gerr);
    chk("t3_lh12_value", got, 32'h00001234);
    do_req("t3_lh10", 1'b0, 3'b001, 32'h10, 32'h0, 0, got, gerr);
    chk("t3_lh10_value", got, 32'hFFFFAAEF);

    do_req("t4_lw13", 1'b0, 3'b010, 32'h13, 32'h0, 0, got, gerr);
    chk("t4_lw13_err", 32'(gerr), 32'd1);
    do_req("t4_sh11", 1'b1, 3'b001, 32'h11, 32'hFFFF, 0, got, gerr);
    chk("t4_sh11_err", 32'(gerr), 32'd1);
    do_req("t4_f011", 1'b0, 3'b011, 32'h10, 32'h0, 0, got, gerr);
    chk("t4_f011_err", 32'(gerr), 32'd1);

    do_req("t5_lw_hold", 1'b0, 3'b010, 32'h10, 32'h0, 3, got, gerr);
    chk("t5_value", got, 32'h1234AAEF);

    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b000;
    bus.req_addr = 32'h20; bus.req_wdata = 32'h55;
    wr0 = wr_cnt;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("t6_in_rmw_rd", 32'(bus.mem_rd_en), 32'd1);
    chk("t6_rmw_addr", bus.mem_addr, 32'h20);
    #1 reset = 1'b1;
    #1;
    chk("t6_rst_wr_en", 32'(bus.mem_wr_en), 32'd0);
    chk("t6_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("t6_rst_req_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_no_resp", 32'(bus.resp_valid), 32'd0);
    chk("t6_no_write", 32'(wr_cnt - wr0), 32'd0);

`ifdef LSU_BOUNDS_CHECK_EN
    do_req("bounds_lw400", 1'b0, 3'b010, 32'h400, 32'h0, 0, got, gerr);
    chk("bounds_err", 32'(gerr), 32'd1);
`endif

    for (int n = 0; n < 300; n++) begin
      logic        rwe;
      logic [2:0]  rf3;
      logic [31:0] ra;
      rwe = 1'($urandom_range(0, 1));
      rf3 = 3'($urandom_range(0, 7));
      ra  = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
      do_req($sformatf("rnd%0d", n), rwe, rf3, ra, $urandom, $urandom_range(0, 2), got, gerr);
    end

    nbad = 0;
    for (int i = 0; i < 256; i++) begin
      w = {rmem[4*i+3], rmem[4*i+2], rmem[4*i+1], rmem[4*i]};
      if (mem[i] !== w) nbad++;
    end
    chk("final_mem_words_wrong", 32'(nbad), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
